// File: rtl/bd_word_arbiter_if.sv
// Word channel bundle between the requester sources and the BD funnel encoder input.
interface bd_word_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 30
);
  logic [NUM_REQ*WORD_W-1:0] in_d;
  logic [NUM_REQ-1:0]        in_lock;
  logic [NUM_REQ-1:0]        in_v;
  logic [NUM_REQ-1:0]        in_a;
  logic [WORD_W-1:0]         out_d;
  logic                      out_v;
  logic                      out_a;

  // Arbiter side: consumes requester words, produces encoder words.
  modport slave (
    input  in_d, in_lock, in_v, out_a,
    output in_a, out_d, out_v
  );

  // Environment side: requesters plus encoder.
  modport master (
    output in_d, in_lock, in_v, out_a,
    input  in_a, out_d, out_v
  );
endinterface

// File: rtl/bd_word_arbiter.sv
// Round-robin, packet-atomic arbiter feeding the BD funnel encoder input
// through a single output register.
module bd_word_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 30,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned GID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  bd_word_arbiter_if.slave bus,
  output logic [GID_W-1:0] grant_id,
  output logic             granted,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WORD_W-1:0]  out_d_q, out_d_d;
  logic               out_v_q, out_v_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [NUM_REQ-1:0] in_a_c;
  logic [GID_W-1:0]   pick_idx;
  logic               pick_found;
  logic [WORD_W-1:0]  req_word [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_word[gi] = bus.in_d[gi*WORD_W +: WORD_W];
  end

  // First valid requester searching upward from rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    int unsigned      cand;
    logic [GID_W-1:0] cand_idx;
    cand       = 0;
    cand_idx   = '0;
    pick_idx   = rr_ptr_q;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = GID_W'(cand);
      if (!pick_found && bus.in_v[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state, acknowledge and output-register load/drain.
  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    out_d_d     = out_d_q;
    out_v_d     = out_v_q;
    pkt_count_d = pkt_count_q;
    in_a_c      = '0;

    if (out_v_q && bus.out_a) begin
      out_v_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_id_d = pick_idx;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        in_a_c[grant_id_q] = bus.in_v[grant_id_q] & (~out_v_q | bus.out_a);
        if (in_a_c[grant_id_q]) begin
          out_d_d = req_word[grant_id_q];
          out_v_d = 1'b1;
          // Last word of the packet: release and demote this requester.
          if (!bus.in_lock[grant_id_q]) begin
            pkt_count_d = pkt_count_q + CNT_W'(1);
            rr_ptr_d    = (grant_id_q == GID_W'(NUM_REQ - 1)) ? '0
                                                               : grant_id_q + GID_W'(1);
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      out_d_q     <= '0;
      out_v_q     <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      out_d_q     <= out_d_d;
      out_v_q     <= out_v_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign bus.in_a  = in_a_c;
  assign bus.out_d = out_d_q;
  assign bus.out_v = out_v_q;
  assign grant_id  = grant_id_q;
  assign granted   = (state_q == ST_GRANT);
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_bd_word_arbiter.sv
// Bench for bd_word_arbiter: queue-driven sources, transaction model,
// per-cycle compare and an output scoreboard.
module tb_bd_word_arbiter;
  localparam int unsigned NUM = 4;
  localparam int unsigned WW  = 30;
  localparam int unsigned CW  = 16;
  localparam int unsigned GW  = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [GW-1:0] grant_id;
  logic          granted;
  logic [CW-1:0] pkt_count;

  always #5 clk = ~clk;

  bd_word_arbiter_if #(.NUM_REQ(NUM), .WORD_W(WW)) bus ();

  bd_word_arbiter #(.NUM_REQ(NUM), .WORD_W(WW), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .grant_id  (grant_id),
    .granted   (granted),
    .pkt_count (pkt_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  // Word format: {source[5:0], last, seq[22:0]}; leaf code = source.
  logic [WW:0]   srcq [NUM][$];
  bit            presenting [NUM];
  bit            acked [NUM];
  bit            gate [NUM];
  bit            rnd_mode = 1'b0;
  int            nseq [NUM];
  int            exp_seq [NUM];
  int            n_pushed = 0;
  int            n_out = 0;
  logic [WW-1:0] outq [$];
  int            expq [$];
  bit            sb_en = 1'b1;
  bit            chk_en = 1'b0;
  int            prev_src = 0;
  bit            prev_open = 1'b0;

  task automatic push_word(input int s, input logic lk);
    logic [WW-1:0] word;
    word = {6'(s), ~lk, 23'(nseq[s])};
    nseq[s]++;
    n_pushed++;
    srcq[s].push_back({lk, word});
  endtask

  task automatic push_pkt(input int s, input int len);
    for (int w = 0; w < len; w++) push_word(s, logic'(w < len - 1));
  endtask

  task automatic drive_sources();
    logic [WW:0] tmp;
    for (int i = 0; i < NUM; i++) begin
      if (acked[i]) begin
        tmp = srcq[i].pop_front();
        presenting[i] = 1'b0;
        acked[i] = 1'b0;
      end
      if (rnd_mode) gate[i] = ($urandom_range(0, 3) == 0);
      if (!presenting[i] && srcq[i].size() > 0 && !gate[i]) begin
        tmp = srcq[i][0];
        bus.in_d[i*WW +: WW] = tmp[WW-1:0];
        bus.in_lock[i] = tmp[WW];
        presenting[i] = 1'b1;
      end
      bus.in_v[i] = presenting[i];
    end
    if (rnd_mode) bus.out_a = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_sources();
  endtask

  function automatic bit busy_src();
    bit b;
    b = 1'b0;
    for (int i = 0; i < NUM; i++) if (srcq[i].size() > 0 || presenting[i]) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int cyc;
    bit done;
    cyc = 0;
    done = 1'b0;
    while (cyc < budget) begin
      done = !bus.out_v && !granted && !busy_src();
      if (done) break;
      tick();
      cyc++;
    end
    chk({"drain_", name}, 64'(done), 64'(1));
  endtask

  task automatic check_leaves(input string name);
    logic [WW-1:0] w;
    chk({name, "_len"}, 64'(outq.size()), 64'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      if (i < outq.size()) begin
        w = outq[i];
        chk(name, 64'(w[29:24]), 64'(expq[i]));
      end
    end
  endtask

  // Transfer capture and output scoreboard (ordering, no loss, no interleave).
  always @(negedge clk) begin : p_sample
    logic [WW-1:0] w;
    int s;
    if (reset === 1'b1) begin
      for (int i = 0; i < NUM; i++) acked[i] = bus.in_v[i] & bus.in_a[i];
      if (bus.out_v && bus.out_a) begin
        w = bus.out_d;
        outq.push_back(w);
        n_out++;
        if (sb_en) begin
          s = int'(w[29:24]);
          if (s >= NUM) chk("sb_src", 64'(s), 64'(0));
          else begin
            chk("sb_seq", 64'(w[22:0]), 64'(23'(exp_seq[s])));
            exp_seq[s] = int'(w[22:0]) + 1;
            if (prev_open) chk("sb_atomic", 64'(s), 64'(prev_src));
            prev_open = !w[23];
            prev_src = s;
          end
        end
      end
    end
  end

  // Behavioural model: owner of the funnel (-1 = arbitrating), fairness
  // pointer, one-word output buffer and completed packet count.
  int            m_owner = -1;
  int            m_rr = 0;
  int            m_gid = 0;
  int            m_cnt = 0;
  bit            m_ov = 1'b0;
  logic [WW-1:0] m_od = '0;

  always @(posedge clk) begin : p_model
    bit drain;
    int idx;
    if (reset === 1'b0) begin
      m_owner = -1; m_rr = 0; m_gid = 0; m_cnt = 0; m_ov = 1'b0; m_od = '0;
    end else begin
      drain = m_ov && bus.out_a;
      if (m_owner < 0) begin
        for (int k = 0; k < NUM; k++) begin
          idx = (m_rr + k) % NUM;
          if (m_owner < 0 && bus.in_v[idx]) begin
            m_owner = idx;
            m_gid = idx;
          end
        end
        if (drain) m_ov = 1'b0;
      end else if (bus.in_v[m_owner] && (!m_ov || bus.out_a)) begin
        m_od = bus.in_d[m_owner*WW +: WW];
        m_ov = 1'b1;
        if (!bus.in_lock[m_owner]) begin
          m_cnt = (m_cnt + 1) % 65536;
          m_rr = (m_owner + 1) % NUM;
          m_owner = -1;
        end
      end else if (drain) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : p_cmp
    logic [NUM-1:0] ea;
    if (chk_en) begin
      ea = '0;
      if (m_owner >= 0 && bus.in_v[m_owner] && (!m_ov || bus.out_a)) ea[m_owner] = 1'b1;
      chk("in_a", 64'(bus.in_a), 64'(ea));
      chk("out_v", 64'(bus.out_v), 64'(m_ov));
      chk("out_d", 64'(bus.out_d), 64'(m_od));
      chk("granted", 64'(granted), 64'(m_owner >= 0));
      chk("grant_id", 64'(grant_id), 64'(m_gid));
      chk("pkt_count", 64'(pkt_count), 64'(m_cnt));
    end
  end

  initial begin
    logic [WW-1:0] tw;
    int c;
    int tot;
    reset = 1'b0;
    bus.in_d = '0;
    bus.in_lock = '0;
    bus.in_v = '0;
    bus.out_a = 1'b1;

    // Reset held with every source valid.
    for (int r = 0; r < 2; r++) for (int i = 0; i < NUM; i++) push_pkt(i, 1);
    drive_sources();
    for (int r = 0; r < 3; r++) begin
      tick();
      chk_en = 1'b1;
      chk("rst_in_a", 64'(bus.in_a), 64'(0));
      chk("rst_out_v", 64'(bus.out_v), 64'(0));
      chk("rst_granted", 64'(granted), 64'(0));
      chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    end
    reset = 1'b1;

    // First grant latency and round-robin order.
    tick();
    chk("lat_granted", 64'(granted), 64'(1));
    chk("lat_grant_id", 64'(grant_id), 64'(0));
    chk("lat_out_v0", 64'(bus.out_v), 64'(0));
    tick();
    tw = bus.out_d;
    chk("lat_out_v1", 64'(bus.out_v), 64'(1));
    chk("lat_leaf", 64'(tw[29:24]), 64'(0));
    wait_idle("rr", 200);
    expq = {0, 1, 2, 3, 0, 1, 2, 3};
    check_leaves("rr_order");
    chk("rr_pkt_count", 64'(pkt_count), 64'(8));
    outq.delete();

    // Atomicity: 3-word packet from requester 2 before requester 0.
    push_pkt(2, 3);
    tick();
    push_pkt(0, 1);
    wait_idle("atomic", 200);
    expq = {2, 2, 2, 0};
    check_leaves("atomic_order");
    chk("atomic_pkt_count", 64'(pkt_count), 64'(10));
    outq.delete();

    // Stall inside a packet: requester 1 goes quiet, requester 3 waits.
    push_word(1, 1'b1);
    push_pkt(3, 1);
    c = 0;
    while (srcq[1].size() > 0 && c < 50) begin tick(); c++; end
    chk("stall_first_word", 64'(srcq[1].size()), 64'(0));
    for (int r = 0; r < 5; r++) begin
      tick();
      chk("stall_grant_id", 64'(grant_id), 64'(1));
      chk("stall_granted", 64'(granted), 64'(1));
      chk("stall_ack3", 64'(bus.in_a[3]), 64'(0));
    end
    push_word(1, 1'b0);
    wait_idle("stall", 200);
    expq = {1, 1, 3};
    check_leaves("stall_order");
    chk("stall_pkt_count", 64'(pkt_count), 64'(12));
    outq.delete();

    // Random sources and random backpressure.
    rnd_mode = 1'b1;
    tot = 0;
    while (tot < 10000) begin
      c = $urandom_range(1, 4);
      push_pkt(int'($urandom_range(0, NUM - 1)), c);
      tot += c;
    end
    wait_idle("random", 60000);
    rnd_mode = 1'b0;
    for (int i = 0; i < NUM; i++) gate[i] = 1'b0;
    bus.out_a = 1'b1;
    chk("sb_count", 64'(n_out), 64'(n_pushed));

    // Reset during word 2 of a 4-word packet.
    sb_en = 1'b0;
    outq.delete();
    push_pkt(0, 4);
    c = 0;
    while (srcq[0].size() > 3 && c < 50) begin tick(); c++; end
    reset = 1'b0;
    tick();
    chk("mid_out_v", 64'(bus.out_v), 64'(0));
    chk("mid_granted", 64'(granted), 64'(0));
    chk("mid_pkt_count", 64'(pkt_count), 64'(0));
    chk("mid_in_a", 64'(bus.in_a), 64'(0));
    for (int i = 0; i < NUM; i++) begin
      srcq[i].delete();
      presenting[i] = 1'b0;
      acked[i] = 1'b0;
    end
    push_word(1, 1'b0);
    push_word(0, 1'b0);
    drive_sources();
    tick();
    reset = 1'b1;
    outq.delete();
    wait_idle("post_reset", 100);
    expq = {0, 1};
    check_leaves("post_reset_order");
    chk("post_reset_pkt_count", 64'(pkt_count), 64'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
